// File: rtl/mux_scheduler.sv
// mux_scheduler: round-robin arbiter and sequencer in front of the shared mux.
// Holds one channel from selection through settle and grant until the
// requester reports completion, then releases for one cycle.
// Optional feature macro: MUX_SCHED_TIMEOUT_EN (GRANT watchdog; default off,
// in which case timeout_out is tied low and GRANT lasts until done/abort).
module mux_scheduler #(
  parameter int SIZE           = 3,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic [SIZE-1:0] req_in,
  input  logic            done_in,
  output logic [SIZE-1:0] select_out,
  output logic [SIZE-1:0] grant_out,
  output logic            enable_out,
  output logic            busy_out,
  output logic            timeout_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_GRANT, ST_RELEASE} state_t;

  localparam logic [SIZE-1:0] LAST_IDX    = SIZE'(SIZE - 1);
  localparam logic [SIZE-1:0] ONE_IDX     = SIZE'(1);
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // Counter widths are fixed, so reject parameters that would not fit.
  generate
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("SETTLE_CYCLES must fit the 8-bit settle counter");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 16-bit watchdog counter");
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [SIZE-1:0] sel_reg, sel_next;
  logic [SIZE-1:0] last_reg, last_next;
  logic [7:0]      settle_cnt_reg, settle_cnt_next;
  logic [SIZE-1:0] grant_reg, grant_next;
  logic            enable_reg, enable_next;
  logic            busy_reg, busy_next;
  logic [SIZE-1:0] sel_onehot;
  logic [SIZE-1:0] next_onehot;
  logic            sel_req;
  logic [SIZE-1:0] cand;
  logic [SIZE-1:0] pick_idx;
  logic            pick_valid;

  // Binary index to one-hot, without variable-width bit selects.
  function automatic logic [SIZE-1:0] idx_to_oh(input logic [SIZE-1:0] idx);
    logic [SIZE-1:0] oh;
    oh = '0;
    for (int b = 0; b < SIZE; b++) begin
      if (idx == SIZE'(b)) oh[b] = 1'b1;
    end
    return oh;
  endfunction

  // One-hot decode of the current selection; sel_req is the held channel's request.
  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_sel_dec
      assign sel_onehot[gi] = (sel_reg == SIZE'(gi));
    end
  endgenerate
  assign sel_req = |(req_in & sel_onehot);

  // Round-robin search: first requesting channel after the last grant, wrapping.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = last_reg;
    for (int i = 0; i < SIZE; i++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + ONE_IDX;
      if (!pick_valid && (|(req_in & idx_to_oh(cand)))) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef MUX_SCHED_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_reg, tmo_cnt_next;
  logic        timeout_reg, timeout_next_w;

  // Watchdog counts GRANT cycles; it is zero on every GRANT entry.
  always_comb begin
    tmo_cnt_next = (state_reg == ST_GRANT) ? tmo_cnt_reg + 16'd1 : '0;
  end

  // Watchdog counter and timeout pulse registers.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      timeout_reg <= timeout_next_w;
    end
  end

  assign timeout_out = timeout_reg;
`else
  assign timeout_out = 1'b0;
`endif

  // Next-state and next-output logic for the select/settle/grant/release sequence.
  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    last_next       = last_reg;
    settle_cnt_next = settle_cnt_reg;
`ifdef MUX_SCHED_TIMEOUT_EN
    timeout_next_w  = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          sel_next        = pick_idx;
          last_next       = pick_idx;
          settle_cnt_next = '0;
          state_next      = (SETTLE_CYCLES == 0) ? ST_GRANT : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!sel_req) begin
          state_next = ST_RELEASE;
        end else if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = ST_GRANT;
        end else begin
          settle_cnt_next = settle_cnt_reg + 8'd1;
        end
      end
      ST_GRANT: begin
        // done_in and a dropped request both end the transaction; new requests
        // from other channels are only considered back in IDLE.
        if (done_in || !sel_req) begin
          state_next = ST_RELEASE;
        end
`ifdef MUX_SCHED_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_LAST) begin
          state_next     = ST_RELEASE;
          timeout_next_w = 1'b1;
        end
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  assign next_onehot = idx_to_oh(sel_next);
  always_comb begin
    grant_next  = (state_next == ST_GRANT) ? next_onehot : '0;
    enable_next = (state_next == ST_GRANT);
    busy_next   = (state_next != ST_IDLE);
  end

  // State, pointer and output registers with asynchronous reset.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= '0;
      last_reg       <= LAST_IDX;
      settle_cnt_reg <= '0;
      grant_reg      <= '0;
      enable_reg     <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      last_reg       <= last_next;
      settle_cnt_reg <= settle_cnt_next;
      grant_reg      <= grant_next;
      enable_reg     <= enable_next;
      busy_reg       <= busy_next;
    end
  end

  assign select_out = sel_reg;
  assign grant_out  = grant_reg;
  assign enable_out = enable_reg;
  assign busy_out   = busy_reg;

endmodule
